// File: rtl/mem_pkg.sv
// Shared types for the memory responder.
// Holds the access-size encodings, the FSM state encoding and the
// alignment check used to reject illegal requests.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_ERR
  } state_t;

  // 1 when the size/low-address pair cannot be serviced.
  function automatic logic misaligned(input size_t sz, input logic [1:0] addr_lo);
    case (sz)
      SZ_WORD: return addr_lo != 2'b00;
      SZ_HALF: return addr_lo[0];
      SZ_BYTE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU (master) and the memory responder (slave).
//   req, we, size, addr, wdata : request side, driven by the master
//   rdata, ack, misalign, busy : response side, driven by the slave
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        misalign;
  logic        busy;

  modport master (
    output req, we, size, addr, wdata,
    input  rdata, ack, misalign, busy
  );

  modport slave (
    input  req, we, size, addr, wdata,
    output rdata, ack, misalign, busy
  );
endinterface

// File: rtl/mem_byte_lanes.sv
// Combinational store-lane steering.
//   size      : access size
//   addr_lo   : byte lane of the access (addr[1:0])
//   wdata     : right-justified store data
//   be        : per-lane byte enable
//   lane_data : store data moved onto its lanes
module mem_byte_lanes
  import mem_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_data
);

  always_comb begin
    be        = '0;
    lane_data = '0;
    case (size)
      SZ_WORD: begin
        be        = '1;
        lane_data = wdata;
      end
      SZ_HALF: begin
        be        = 4'b0011 << addr_lo;
        lane_data = {16'h0000, wdata[15:0]} << {addr_lo, 3'b000};
      end
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        lane_data = {24'h000000, wdata[7:0]} << {addr_lo, 3'b000};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder with programmable wait states.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus          : slave side of mem_responder_if
// Accepts a request pulse in IDLE, waits WAIT_CYCLES cycles, then does an
// aligned word read or a lane-masked store and pulses ack. Misaligned
// requests are answered with ack+misalign and touch nothing.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                we_q;
  size_t               size_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;

  logic [31:0]         rdata_q;
  logic                ack_q;
  logic                misalign_q;
  logic                busy_q;

  logic [3:0]          be;
  logic [31:0]         lane_data;
  logic [ADDR_W-1:0]   idx;
  logic                wr_en;

  // One 8-bit array per byte lane; contents are never reset.
  logic [7:0]          ram [4][DEPTH];

  // Address bits above the array depth wrap and are deliberately ignored.
  logic                unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

  assign idx   = addr_q[ADDR_W+1:2];
  assign wr_en = (state == ST_ACCESS) && we_q;

  assign bus.rdata    = rdata_q;
  assign bus.ack      = ack_q;
  assign bus.misalign = misalign_q;
  assign bus.busy     = busy_q;

  mem_byte_lanes u_lanes (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .be        (be),
    .lane_data (lane_data)
  );

  // ack/misalign are registered at the edge that leaves ACCESS/ERR, so the
  // strobe is seen while the FSM is already back in IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      size_q     <= SZ_WORD;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      misalign_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ack_q      <= 1'b0;
      misalign_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            size_q  <= size_t'(bus.size);
            addr_q  <= bus.addr[ADDR_W+1:0];
            wdata_q <= bus.wdata;
            busy_q  <= 1'b1;
            if (misaligned(size_t'(bus.size), bus.addr[1:0])) begin
              state <= ST_ERR;
            end else if (WAIT_CYCLES == 0) begin
              state <= ST_ACCESS;
            end else begin
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state <= ST_ACCESS;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_ACCESS: begin
          if (!we_q) begin
            rdata_q <= {ram[3][idx], ram[2][idx], ram[1][idx], ram[0][idx]};
          end
          ack_q  <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        ST_ERR: begin
          ack_q      <= 1'b1;
          misalign_q <= 1'b1;
          busy_q     <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (be[l]) begin
          ram[l][idx] <= lane_data[8*l +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int unsigned W = 2;

  logic clock = 1'b0;
  logic reset;

  mem_responder_if bus();

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] mem_m [256];
  logic [31:0] rdata_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    bus.we    = 1'($urandom);
    bus.size  = 2'($urandom);
    bus.addr  = $urandom;
    bus.wdata = $urandom;
  endtask

  // Issue one request, follow it to its ack and compare against the model.
  // Entered and left just after a rising edge.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int unsigned lat;
    int unsigned idx;
    int unsigned lane;
    logic        bad;
    logic [31:0] word;
    bus.req   = 1'b1;
    bus.we    = w;
    bus.size  = sz;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clock); #1;
    bus.req = 1'b0;
    scramble();
    bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b00 && a[1:0] != 2'b00);
    if (!bad) check({tag, " busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      if (bus.ack) begin
        lat = i;
        break;
      end
    end
    idx  = (a >> 2) & 32'hFF;
    lane = a[1:0];
    if (!bad) begin
      if (w) begin
        word = mem_m[idx];
        case (sz)
          2'b10:   word[8*lane +: 8]  = d[7:0];
          2'b01:   word[8*lane +: 16] = d[15:0];
          default: word = d;
        endcase
        mem_m[idx] = word;
      end else begin
        rdata_m = mem_m[idx];
      end
    end
    check({tag, " latency"}, lat, bad ? 32'd1 : W + 1);
    check({tag, " misalign"}, 32'(bus.misalign), 32'(bad));
    check({tag, " rdata"}, bus.rdata, rdata_m);
    @(posedge clock); #1;
    check({tag, " ack_drop"}, 32'(bus.ack), 32'd0);
    check({tag, " busy_drop"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int unsigned acks;
    logic [1:0]  sz;
    logic [31:0] a;

    reset   = 1'b1;
    bus.req = 1'b0;
    scramble();
    repeat (3) @(posedge clock);
    #1;
    check("rst ack", 32'(bus.ack), 32'd0);
    check("rst misalign", 32'(bus.misalign), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst rdata", bus.rdata, 32'd0);
    reset   = 1'b0;
    rdata_m = '0;
    @(posedge clock); #1;

    // Give every word a known value.
    for (int i = 0; i < 256; i++) do_req(1'b1, 2'b00, 32'(i * 4), 32'd0, "init");

    do_req(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, "word_st");
    do_req(1'b0, 2'b00, 32'h10, 32'h0, "word_ld");
    check("plan word", bus.rdata, 32'hDEADBEEF);
    do_req(1'b1, 2'b10, 32'h12, 32'hAA, "byte_st");
    do_req(1'b0, 2'b00, 32'h10, 32'h0, "merge_ld");
    check("plan byte merge", bus.rdata, 32'hDEAABEEF);
    do_req(1'b1, 2'b01, 32'h16, 32'h1234, "half_st");
    do_req(1'b0, 2'b00, 32'h14, 32'h0, "half_ld");
    check("plan half", bus.rdata, 32'h12340000);

    do_req(1'b1, 2'b00, 32'h21, 32'hFFFFFFFF, "mis_word");
    do_req(1'b1, 2'b01, 32'h23, 32'hFFFFFFFF, "mis_half");
    do_req(1'b1, 2'b11, 32'h20, 32'hFFFFFFFF, "mis_rsvd");
    do_req(1'b0, 2'b00, 32'h20, 32'h0, "mis_ld");
    check("plan mis untouched", bus.rdata, 32'h0);

    // A second req during WAIT must be dropped.
    bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b00; bus.addr = 32'h10; bus.wdata = 32'h0;
    @(posedge clock); #1;
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.addr = 32'h40; bus.wdata = 32'hFFFFFFFF;
    @(posedge clock); #1;
    bus.req = 1'b0;
    acks = 0;
    for (int i = 2; i <= 12; i++) begin
      @(posedge clock); #1;
      if (bus.ack) acks++;
    end
    rdata_m = mem_m[4];
    check("ignored ack count", acks, 32'd1);
    check("ignored rdata", bus.rdata, 32'hDEAABEEF);
    do_req(1'b0, 2'b00, 32'h40, 32'h0, "ignored_ld");
    check("ignored no write", bus.rdata, 32'h0);

    do_req(1'b1, 2'b10, 32'h400, 32'h55, "wrap_st");
    do_req(1'b0, 2'b00, 32'h0, 32'h0, "wrap_ld");
    check("wrap lane0", bus.rdata, 32'h00000055);

    // Reset during WAIT of a store aborts it.
    do_req(1'b1, 2'b00, 32'h30, 32'h0BADF00D, "pre_st");
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.addr = 32'h30; bus.wdata = 32'hFFFFFFFF;
    @(posedge clock); #1;
    bus.req = 1'b0;
    reset   = 1'b1;
    #1;
    check("midrst ack", 32'(bus.ack), 32'd0);
    check("midrst misalign", 32'(bus.misalign), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst rdata", bus.rdata, 32'd0);
    @(posedge clock); #1;
    reset   = 1'b0;
    rdata_m = '0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (bus.ack) acks++;
    end
    check("midrst no ack", acks, 32'd0);
    do_req(1'b0, 2'b00, 32'h30, 32'h0, "midrst_ld");
    check("midrst prior data", bus.rdata, 32'h0BADF00D);

    for (int n = 0; n < 300; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom & 32'hFFFF_F03F;
      do_req(1'($urandom), sz, a, $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
